reg_dump: RTL and testbench
===========================

REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter NREG, default 32, number of registers scanned (even, 2..64).
REQ-002 Parameter DW, default 32, register word width.
REQ-003 Parameter AW, default 6, register address width (matches R1/R2/RD of the register file).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 start  input  1  request a full register-file dump; sampled only in IDLE.
REQ-007 abort  input  1  terminate a dump in progress.
REQ-008 R1  output  AW  register-file read address, port 1.
REQ-009 R2  output  AW  register-file read address, port 2.
REQ-010 s1  input  DW  register-file read data for R1 (combinational).
REQ-011 s2  input  DW  register-file read data for R2 (combinational).
REQ-012 dout  output  DW  streamed register value.
REQ-013 dout_addr  output  AW  register index of dout.
REQ-014 dout_valid  output  1  dout/dout_addr valid.
REQ-015 dout_ready  input  1  consumer accepts the word when high with dout_valid.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse at normal dump completion.
REQ-018 checksum  output  DW  XOR of all words accepted in the current/last dump.

Function
REQ-019 FSM states IDLE, FETCH, SEND0, SEND1, DONE; pair pointer ptr (AW bits, even values only).
REQ-020 IDLE: R1=R2=0, dout_valid=0; start=1 -> FETCH, ptr=0, checksum cleared to 0.
REQ-021 FETCH (exactly 1 cycle): R1=ptr, R2=ptr+1; at edge capture s1->buf0, s2->buf1; -> SEND0.
REQ-022 SEND0: dout=buf0, dout_addr=ptr, dout_valid=1; on dout_ready -> SEND1, checksum ^= buf0.
REQ-023 SEND1: dout=buf1, dout_addr=ptr+1, dout_valid=1; on dout_ready checksum ^= buf1; if ptr+2==NREG -> DONE, else ptr+=2 -> FETCH.
REQ-024 While dout_valid=1 and dout_ready=0, dout and dout_addr hold stable; no word is dropped or duplicated.
REQ-025 R1/R2 hold the FETCH addresses through SEND0/SEND1; buffered data is not re-sampled, so register-file writes after FETCH do not alter the pair being sent.
REQ-026 DONE (1 cycle): done=1, dout_valid=0; -> IDLE; checksum held until the next accepted start.
REQ-027 start outside IDLE ignored; start and abort high together in IDLE: abort wins, stays IDLE.
REQ-028 abort=1 in any non-IDLE state -> IDLE next edge, no done pulse, no checksum update that cycle even if dout_ready=1.
REQ-029 Latency with dout_ready held 1: start at edge k -> first dout_valid in cycle k+2, done in cycle k+1+3*(NREG/2) (k+49 for NREG=32).
REQ-030 Register 0 is streamed like any other (value as returned by s1).

Reset
REQ-031 reset=0 at a rising edge: state IDLE, ptr=0, buf0=buf1=0, checksum=0, done=0, dout_valid=0, dout=0, dout_addr=0, R1=R2=0, busy=0.
REQ-032 Reset mid-dump aborts immediately, no done pulse; reset dominates start and abort.

Verification
REQ-033 Regfile model reg[i]=i*3, ready=1, start pulse -> 32 words, addr 0..31 in order, dout=i*3, done in cycle k+49, checksum = XOR of i*3 over 0..31.
REQ-034 ready toggling 1,0,0,1 per cycle -> dout/dout_addr stable during stalls, still exactly 32 words, same checksum as REQ-033.
REQ-035 Model writes reg[5]=0xDEADBEEF while SEND0 of pair 4 is stalled -> streamed word for addr 5 is the pre-write value 15.
REQ-036 abort asserted on the 10th accepted word -> IDLE next cycle, busy=0, no done, exactly 10 words seen.
REQ-037 reset=0 in SEND1 of pair 7 -> all outputs zero next cycle; new start produces full 32-word dump from addr 0.
REQ-038 start held high continuously -> dumps run back-to-back, each preceded by one IDLE cycle, checksum restarting at 0 each time.

Source files
------------

// File: rtl/reg_dump.sv
// Streams every register of a register file out as (index, value) words, two registers per
// fetch, over a valid/ready handshake while keeping a running XOR checksum of accepted words.
module reg_dump #(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] R1,
  output logic [AW-1:0] R2,
  input  logic [DW-1:0] s1,
  input  logic [DW-1:0] s2,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] dout_addr,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  localparam int unsigned PW = AW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSend0,
    StSend1,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;
  logic [DW-1:0] checksum_q, checksum_d;

  logic [AW-1:0] ptr_odd;
  logic [PW-1:0] ptr_next2;
  logic          last_pair;

  // ptr is always even, so the odd partner is ptr+1 without carry.
  assign ptr_odd   = ptr_q + AW'(1);
  // One extra bit so NREG == 2**AW still compares correctly on the last pair.
  assign ptr_next2 = {1'b0, ptr_q} + PW'(2);
  assign last_pair = (ptr_next2 == PW'(NREG));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    checksum_d = checksum_q;
    R1         = '0;
    R2         = '0;
    dout       = '0;
    dout_addr  = '0;
    dout_valid = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d    = StFetch;
          ptr_d      = '0;
          checksum_d = '0;
        end
      end
      StFetch: begin
        R1      = ptr_q;
        R2      = ptr_odd;
        buf0_d  = s1;
        buf1_d  = s2;
        state_d = StSend0;
      end
      StSend0: begin
        R1         = ptr_q;
        R2         = ptr_odd;
        dout       = buf0_q;
        dout_addr  = ptr_q;
        dout_valid = 1'b1;
        if (dout_ready) begin
          checksum_d = checksum_q ^ buf0_q;
          state_d    = StSend1;
        end
      end
      StSend1: begin
        R1         = ptr_q;
        R2         = ptr_odd;
        dout       = buf1_q;
        dout_addr  = ptr_odd;
        dout_valid = 1'b1;
        if (dout_ready) begin
          checksum_d = checksum_q ^ buf1_q;
          if (last_pair) begin
            state_d = StDone;
          end else begin
            ptr_d   = ptr_next2[AW-1:0];
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort beats any handshake in the same cycle: nothing is counted and no done pulse.
    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      ptr_d      = ptr_q;
      checksum_d = checksum_q;
      done       = 1'b0;
    end
  end

  assign busy     = (state_q != StIdle);
  assign checksum = checksum_q;

endmodule

// File: tb/tb_reg_dump.sv
// Randomized self-checking bench for reg_dump against a register-file snapshot model.
module tb_reg_dump;

  localparam int unsigned NREG  = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;
  localparam int unsigned NSLOT = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, start, abort, dout_ready;
  logic [AW-1:0] R1, R2, dout_addr;
  logic [DW-1:0] s1, s2, dout, checksum;
  logic          dout_valid, busy, done;

  logic [DW-1:0] reg_model [NSLOT];
  assign s1 = reg_model[R1];
  assign s2 = reg_model[R2];

  reg_dump #(.NREG(NREG), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .R1         (R1),
    .R2         (R2),
    .s1         (s1),
    .s2         (s2),
    .dout       (dout),
    .dout_addr  (dout_addr),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer-side scoreboard: every accepted word, in order.
  logic [AW-1:0] got_addr [$];
  logic [DW-1:0] got_data [$];
  bit            first_seen = 1'b0;
  int unsigned   first_valid_cyc = 0;
  int            done_cnt = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_dout;
  logic [AW-1:0] prev_addr;

  always @(negedge clk) begin
    if (reset && !abort && prev_stall && dout_valid) begin
      check("hold_data", dout, prev_dout);
      check("hold_addr", dout_addr, prev_addr);
    end
    prev_stall = reset && !abort && dout_valid && !dout_ready;
    prev_dout  = dout;
    prev_addr  = dout_addr;
    if (reset && dout_valid && !first_seen) begin
      first_seen      = 1'b1;
      first_valid_cyc = cyc;
    end
    if (reset && !abort && dout_valid && dout_ready) begin
      got_addr.push_back(dout_addr);
      got_data.push_back(dout);
    end
    if (done) done_cnt++;
  end

  // Ready patterns: 0 always high, 1 repeating 1,0,0,1, 2 random, 3 driven by the test.
  int          ready_mode = 0;
  int unsigned pat_idx = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: dout_ready = 1'b1;
      1: begin
        dout_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
        pat_idx++;
      end
      2: dout_ready = ($urandom_range(0, 9) < 6);
      default: ;
    endcase
  end

  logic [DW-1:0] snap [NREG];
  int unsigned   k_start;

  function automatic logic [DW-1:0] exp_xor(input int n);
    logic [DW-1:0] x = '0;
    for (int i = 0; i < n; i++) x ^= snap[i];
    return x;
  endfunction

  task automatic arm_dump();
    for (int i = 0; i < NREG; i++) snap[i] = reg_model[i];
    got_addr.delete();
    got_data.delete();
    first_seen = 1'b0;
  endtask

  task automatic start_dump();
    arm_dump();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    k_start = cyc;
    start   = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int n);
    check({tag, "_count"}, got_addr.size(), n);
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      check({tag, "_addr"}, got_addr[i], i % NREG);
      check({tag, "_data"}, got_data[i], snap[i % NREG]);
    end
  endtask

  task automatic finish_dump(input string tag, input bit timed);
    bit          seen = 1'b0;
    int unsigned dc = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dc   = cyc;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    if (timed) begin
      check({tag, "_first_lat"}, first_valid_cyc - k_start, 1);
      check({tag, "_done_lat"}, dc - k_start, 3 * (NREG / 2));
    end
    check_stream(tag, NREG);
    @(negedge clk);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_csum"}, checksum, exp_xor(NREG));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_addr"}, dout_addr, 0);
    check({tag, "_valid"}, dout_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_r1"}, R1, 0);
    check({tag, "_r2"}, R2, 0);
    check({tag, "_csum"}, checksum, 0);
  endtask

  initial begin
    bit found;
    int dc0;
    reset = 1'b0; start = 1'b1; abort = 1'b1; dout_ready = 1'b1;
    for (int i = 0; i < NSLOT; i++) reg_model[i] = DW'(i * 3);

    // Reset dominates start and abort.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");

    // start and abort together in idle: abort wins.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("sa_busy", busy, 0);
    check("sa_valid", dout_valid, 0);
    start = 1'b0; abort = 1'b0;

    // Straight dump with ready held high, including latency.
    ready_mode = 0;
    start_dump();
    finish_dump("seq", 1'b1);

    // Periodic back-pressure.
    ready_mode = 1; pat_idx = 0;
    start_dump();
    finish_dump("stall", 1'b0);

    // Register write after the pair is fetched must not affect the streamed pair.
    ready_mode = 3; dout_ready = 1'b1;
    start_dump();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (R1 == AW'(4) && !dout_valid) found = 1'b1;
    end
    check("wr_find", found, 1);
    @(posedge clk); #1;
    dout_ready   = 1'b0;
    reg_model[5] = 32'hDEADBEEF;
    check("wr_send0_addr", dout_addr, 4);
    repeat (3) @(posedge clk);
    #1 dout_ready = 1'b1;
    finish_dump("wr", 1'b0);
    if (got_data.size() > 5) check("wr_addr5", got_data[5], 15);
    reg_model[5] = 15;

    // Abort right after the 10th accepted word.
    ready_mode = 0;
    dc0 = done_cnt;
    start_dump();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (got_addr.size() == 10) found = 1'b1;
    end
    check("ab_find", found, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_valid", dout_valid, 0);
    repeat (5) @(posedge clk);
    check_stream("ab", 10);
    check("ab_no_done", done_cnt, dc0);
    check("ab_csum", checksum, exp_xor(10));

    // Reset while sending the odd word of pair 7.
    dc0 = done_cnt;
    start_dump();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (dout_valid && dout_addr == AW'(15)) found = 1'b1;
    end
    check("mr_find", found, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check_zero("mr");
    check("mr_count", got_addr.size(), 15);
    check("mr_no_done", done_cnt, dc0);
    reset = 1'b1;
    start_dump();
    finish_dump("after_rst", 1'b1);

    // start held high: back-to-back dumps, one idle cycle between, checksum restarts.
    arm_dump();
    @(posedge clk); #1;
    start = 1'b1;
    for (int d = 0; d < 2; d++) begin
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
        @(negedge clk);
        if (done) found = 1'b1;
      end
      check("b2b_done", found, 1);
      check("b2b_csum", checksum, exp_xor(NREG));
      @(negedge clk);
      check("b2b_gap", busy, 0);
      @(negedge clk);
      check("b2b_restart", busy, 1);
      check("b2b_clear", checksum, 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("b2b_last_done", found, 1);
    check_stream("b2b", 3 * NREG);

    // Random register contents under random back-pressure.
    ready_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREG; i++) reg_model[i] = $urandom;
      start_dump();
      finish_dump("rand", 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
